// File: rtl/ifu_inst_fetch.sv
// rtl/ifu_inst_fetch.sv - single-outstanding AXI4-Lite instruction fetch with pending PC buffer and flush
module ifu_inst_fetch #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [1:0]  RESP_OKAY = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_change,
  input  logic              flush,
  output logic              fetch_busy,
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  output logic              rready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err,
  input  logic              inst_ready
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic                pend_q, pend_d;
  logic                drop_q, drop_d;
  logic                inst_err_q, inst_err_d;

  logic                pend_nxt;
  logic [ADDR_W-1:0]   pend_pc_nxt;
  logic                release_fetch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      araddr_q   <= '0;
      pend_pc_q  <= '0;
      inst_pc_q  <= '0;
      inst_q     <= '0;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
      inst_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      pend_pc_q  <= pend_pc_d;
      inst_pc_q  <= inst_pc_d;
      inst_q     <= inst_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      inst_err_q <= inst_err_d;
    end
  end

  always_comb begin
    // flush empties the pending slot, but a same-cycle pc_change is the branch target and survives
    pend_nxt    = pend_q && !flush;
    pend_pc_nxt = pend_pc_q;
    if (pc_change && state_q != S_IDLE) begin
      pend_nxt    = 1'b1;
      pend_pc_nxt = pc_in;
    end

    state_d       = state_q;
    araddr_d      = araddr_q;
    pend_d        = pend_nxt;
    pend_pc_d     = pend_pc_nxt;
    inst_pc_d     = inst_pc_q;
    inst_d        = inst_q;
    inst_err_d    = inst_err_q;
    drop_d        = drop_q;
    release_fetch = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pc_change) begin
          state_d  = S_AR;
          araddr_d = pc_in;
        end
      end
      S_AR: begin
        if (flush)   drop_d  = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (flush) drop_d = 1'b1;
        if (rvalid) begin
          if (drop_q || flush) begin
            drop_d        = 1'b0;
            release_fetch = 1'b1;
          end else begin
            inst_d     = rdata;
            inst_pc_d  = araddr_q;
            inst_err_d = (rresp != RESP_OKAY);
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (inst_ready || flush) release_fetch = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // chain straight into the buffered PC so back-to-back fetches lose no idle cycle
    if (release_fetch) begin
      if (pend_nxt) begin
        state_d  = S_AR;
        araddr_d = pend_pc_nxt;
        pend_d   = 1'b0;
      end else begin
        state_d  = S_IDLE;
      end
    end
  end

  always_comb begin
    arvalid    = (state_q == S_AR);
    rready     = (state_q == S_R);
    inst_valid = (state_q == S_HOLD);
    fetch_busy = (state_q != S_IDLE) || pend_q;
  end

  assign araddr   = araddr_q;
  assign inst     = inst_q;
  assign inst_pc  = inst_pc_q;
  assign inst_err = inst_err_q;

endmodule

// File: tb/tb_ifu_inst_fetch.sv
// tb/tb_ifu_inst_fetch.sv - scoreboard bench for ifu_inst_fetch with a transaction-level fetch model
module tb_ifu_inst_fetch;

  localparam logic [1:0] PH_AR = 2'd0, PH_R = 2'd1, PH_HOLD = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_change, flush;
  logic        fetch_busy;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        inst_valid, inst_err, inst_ready;
  logic [31:0] inst, inst_pc;

  always #5 clk = ~clk;

  ifu_inst_fetch #(.ADDR_W(32), .DATA_W(32), .RESP_OKAY(2'b00)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_change(pc_change), .flush(flush),
    .fetch_busy(fetch_busy), .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .inst_ready(inst_ready)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Bench knobs and AXI slave state
  int          p_ar = 100, p_ir = 100, r_dly_max = 0, ar_block = 0, ir_block = 0;
  bit          s_pend = 1'b0;
  logic [31:0] s_addr = '0;
  int          s_wait = 0;

  // Reference model: one fetch in flight plus one buffered PC
  bit          m_busy = 1'b0, m_kill = 1'b0, p_v = 1'b0;
  logic [1:0]  m_ph = PH_AR;
  logic [31:0] m_pc = '0, p_pc = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a[11:8] == 4'hE) return 32'hDEAD_BEEF;
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[11:8] == 4'hE;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_cycle();
    bit         idle0, done;
    logic [3:0] exp_ctl;
    exp_ctl = {m_busy || p_v, m_busy && m_ph == PH_AR, m_busy && m_ph == PH_R, m_busy && m_ph == PH_HOLD};
    check("ctl{busy,arvalid,rready,inst_valid}", 64'({fetch_busy, arvalid, rready, inst_valid}), 64'(exp_ctl));
    if (m_busy && m_ph == PH_AR) check("araddr", 64'(araddr), 64'(m_pc));
    idle0 = !m_busy;
    done  = 1'b0;
    if (flush) begin
      p_v = 1'b0;
      if (m_busy) begin
        if (m_ph != PH_HOLD) m_kill = 1'b1;
        else if (!inst_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_back());
          done = 1'b1;
        end
      end
    end
    if (pc_change) begin
      if (idle0) begin
        m_busy = 1'b1; m_pc = pc_in; m_ph = PH_AR; m_kill = 1'b0;
      end else begin
        p_v = 1'b1; p_pc = pc_in;
      end
    end
    if (!idle0 && !done) begin
      case (m_ph)
        PH_AR:   if (arready) m_ph = PH_R;
        PH_R:    if (rvalid) begin
                   if (m_kill) done = 1'b1;
                   else begin
                     m_ph = PH_HOLD;
                     exp_q.push_back({m_pc, mem_data(m_pc), mem_err(m_pc)});
                   end
                 end
        default: if (inst_ready) done = 1'b1;
      endcase
    end
    if (done) begin
      if (p_v) begin
        m_pc = p_pc; m_ph = PH_AR; m_kill = 1'b0; p_v = 1'b0;
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic step(input bit pcc, input logic [31:0] pc, input bit fl);
    @(negedge clk);
    pc_change  = pcc;
    pc_in      = pcc ? pc : $urandom;
    flush      = fl;
    arready    = (ar_block == 0) && ($urandom_range(99) < p_ar);
    inst_ready = (ir_block == 0) && ($urandom_range(99) < p_ir);
    rvalid     = s_pend && (s_wait == 0);
    rdata      = rvalid ? mem_data(s_addr) : $urandom;
    rresp      = rvalid ? (mem_err(s_addr) ? 2'b10 : 2'b00) : 2'($urandom);
    #2;
    model_cycle();
    if (arvalid && arready) begin
      s_pend = 1'b1; s_addr = araddr; s_wait = int'($urandom_range(r_dly_max, 0));
    end else if (rvalid && rready) s_pend = 1'b0;
    else if (s_pend && s_wait > 0) s_wait--;
    if (arvalid && ar_block > 0) ar_block--;
    if (inst_valid && ir_block > 0) ir_block--;
  endtask

  task automatic wait_phase(input logic [1:0] ph);
    int n = 0;
    while (!(m_busy && m_ph == ph) && n < 50) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    if (!(m_busy && m_ph == ph)) begin
      checks++; failures++;
      $display("FAIL wait_phase timeout phase=%0d", ph);
    end
  endtask

  task automatic drain();
    int n = 0;
    p_ar = 100; p_ir = 100;
    while ((m_busy || p_v) && n < 100) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    step(1'b0, 32'h0, 1'b0);
    check("drain_busy", 64'(fetch_busy), 64'd0);
  endtask

  // Monitor: compares every presented instruction, pops on accept
  always @(negedge clk) begin
    #1;
    if (!rst && inst_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL inst_unexpected actual_pc=%0h required=none", inst_pc);
      end else begin
        check("inst_pc", 64'(inst_pc), 64'(exp_q[0].pc));
        check("inst", 64'(inst), 64'(exp_q[0].data));
        check("inst_err", 64'(inst_err), 64'(exp_q[0].err));
        if (inst_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; pc_in = '0; pc_change = 1'b0; flush = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ctl", 64'({fetch_busy, arvalid, rready, inst_valid, inst_err}), 64'd0);
    check("reset_araddr", 64'(araddr), 64'd0);
    check("reset_inst", 64'({inst, inst_pc}), 64'd0);

    step(1'b1, 32'h8000_0000, 1'b0);
    drain();

    ar_block = 3; ir_block = 2;
    step(1'b1, 32'h8000_0040, 1'b0);
    drain();

    r_dly_max = 2;
    step(1'b1, 32'h8000_0000, 1'b0);
    wait_phase(PH_R);
    step(1'b1, 32'h8000_0004, 1'b0);
    drain();

    r_dly_max = 3;
    step(1'b1, 32'h8000_0008, 1'b0);
    wait_phase(PH_R);
    step(1'b1, 32'h8000_0100, 1'b1);
    drain();

    ar_block = 4;
    step(1'b1, 32'h8000_0010, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    drain();

    step(1'b1, 32'h8000_0E00, 1'b0);
    drain();
    step(1'b1, 32'h8000_0014, 1'b0);
    drain();

    for (int i = 0; i < 3000; i++) begin
      p_ar = 60; p_ir = 60;
      step($urandom_range(99) < 30, {20'h80000, 10'($urandom), 2'b00}, $urandom_range(99) < 5);
    end
    drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_inst_fetch.md
Name: ifu_inst_fetch

Overview:
Instruction-fetch engine that consumes the PC value and the one-cycle pc_change pulse produced by the IFU PC counter. It issues one AXI4-Lite read per PC to instruction memory and returns the fetched word, tagged with its PC, to the decode stage over a valid/ready handshake. It drives a busy/stall signal back to the PC counter and discards in-flight fetches when a branch redirect flushes the front end.

Parameters:
ADDR_W, 32, width of PC and araddr
DATA_W, 32, width of instruction / rdata
RESP_OKAY, 2'b00, rresp value treated as success

Ports:
clk  input  1  clock
rst  input  1  reset rst, synchronous, active-high; clock clk
pc_in  input  ADDR_W  current PC from the PC counter
pc_change  input  1  one-cycle pulse: pc_in holds a new PC to fetch
flush  input  1  branch redirect; kill every older fetch
fetch_busy  output  1  stall request to the PC counter
arvalid  output  1  AXI read-address valid
araddr  output  ADDR_W  AXI read address
arready  input  1  AXI read-address ready
rvalid  input  1  AXI read-data valid
rdata  input  DATA_W  AXI read data
rresp  input  2  AXI read response
rready  output  1  AXI read-data ready
inst_valid  output  1  fetched instruction valid to decode
inst  output  DATA_W  fetched instruction
inst_pc  output  ADDR_W  PC of inst
inst_err  output  1  rresp was not RESP_OKAY for this fetch
inst_ready  input  1  decode accepts instruction

Behaviour:
- States: IDLE, AR (arvalid=1, waiting for arready), R (rready=1, waiting for rvalid), HOLD (inst_valid=1, waiting for inst_ready).
- Reset: state=IDLE; arvalid=0, rready=0, inst_valid=0, inst_err=0; araddr, inst, inst_pc=0; pending=0; drop=0. Reset mid-transaction abandons everything with no AXI completion.
- Request capture: pc_change in IDLE latches pc_in into araddr. Next cycle the state is AR with arvalid=1 (registered, so one cycle from the pulse to arvalid).
- pc_change outside IDLE writes pc_in into a one-entry pending buffer. A newer pulse overwrites the buffered PC. On return to IDLE with pending=1, the block goes straight to AR with araddr=pending PC and clears pending.
- AR: araddr and arvalid stay stable until arready. On arvalid&&arready, go to R.
- R: rready=1. On rvalid, capture rdata into inst, araddr into inst_pc, and (rresp!=RESP_OKAY) into inst_err. Go to HOLD with inst_valid=1, unless drop=1; in that case discard the data, clear drop, and go to IDLE (or to AR if pending).
- HOLD: inst, inst_pc and inst_err are stable. On inst_ready, clear inst_valid and go to IDLE, or to AR if pending.
- Fastest path: pulse at cycle 0, arvalid at cycle 1, R at cycle 2, rvalid at cycle 2, inst_valid at cycle 3.
- flush:
  - In AR: arvalid is not withdrawn (AXI rule); set drop=1.
  - In R: set drop=1.
  - In HOLD: inst_valid=0 next cycle, go to IDLE.
  - flush always clears pending.
  - flush and pc_change in the same cycle: the pc_change PC (the branch target) is kept as the next request and is not dropped.
- fetch_busy = (state!=IDLE) || pending, combinational.
- Error responses do not stop fetching; inst_err only flags the bad word.
- Only one AXI transaction is outstanding at any time.

Test Plan:
- Reset, then pc_change with pc_in=0x80000000; arready=1, rvalid at cycle 2 with rdata=0x00000413, rresp=0 -> araddr=0x80000000 at cycle 1; inst_valid=1 at cycle 3 with inst=0x00000413, inst_pc=0x80000000, inst_err=0.
- arready held low 3 cycles, inst_ready low 2 cycles -> arvalid/araddr stable throughout; inst stable in HOLD; fetch_busy=1 until the cycle after inst_ready.
- pc_change 0x80000004 while in R for 0x80000000 -> after HOLD completes, araddr=0x80000004 is issued with no extra idle cycle; both instructions delivered in order.
- flush in R for 0x80000008 with a simultaneous pc_change of 0x80000100 -> rvalid data for 0x80000008 is discarded (inst_valid stays 0); next delivered inst_pc=0x80000100.
- flush in AR while arready=0 -> arvalid held until handshake, returned data dropped, state returns to IDLE, fetch_busy=0.
- rresp=2'b10 with rdata=0xDEADBEEF -> inst_valid=1, inst_err=1; the next fetch's inst_err=0.
